// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, sample type and the
// output-stage state encoding.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [7:0] URUN_MAX = 8'hFF;

endpackage

// File: rtl/dsm1.sv
// First-order error-feedback delta-sigma modulator. The carry out of the
// phase accumulator is the output bit, so the ones density is active/2^WIDTH.
module dsm1
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] active,
  output logic             pdm_out
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pdm_q, pdm_d;
  logic [WIDTH:0]   sum;

  // Accumulate while running; hold the accumulator and output at zero otherwise.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, active};
    acc_d = '0;
    pdm_d = 1'b0;
    if (run) begin
      acc_d = sum[WIDTH-1:0];
      pdm_d = sum[WIDTH];
    end
  end

  // Accumulator and output bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule

// File: rtl/pdm_dac.sv
// PDM output stage: one-entry input buffer, programmable sample timer,
// sequencing FSM and underrun accounting around a first-order modulator.
//
//   state | meaning
//   IDLE  | enable low; modulator cleared, timer held at div, buffer still accepts
//   PRIME | enabled, waiting for the first tick that finds a buffered sample
//   RUN   | streaming; empty-buffer ticks are underruns
module pdm_dac
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             pdm_out,
  output logic             sample_tick,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  state_t           state_q, state_d, state_eff;
  logic [DIV_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             buf_full_q, buf_full_d;
  logic             sample_tick_q, sample_tick_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       underrun_cnt_q, underrun_cnt_d;
  logic             tick;
  logic             xfer;

  // Next-state logic for the timer, buffer, FSM and underrun accounting.
  always_comb begin
    // The cycle enable is first seen already behaves as PRIME, so the first
    // tick lands exactly div cycles after enable rises.
    state_eff = state_q;
    if (!enable) begin
      state_eff = IDLE;
    end else if (state_q == IDLE) begin
      state_eff = PRIME;
    end

    cnt_eff = (state_q == IDLE) ? div : cnt_q;
    tick    = enable && (cnt_eff == '0);
    xfer    = din_valid && !buf_full_q;

    state_d        = state_eff;
    cnt_d          = div;
    buf_d          = buf_q;
    buf_full_d     = buf_full_q;
    active_d       = active_q;
    sample_tick_d  = 1'b0;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;

    if (!enable) begin
      underrun_d     = 1'b0;
      underrun_cnt_d = '0;
    end else begin
      cnt_d = tick ? div : (cnt_eff - CNT_ONE);
      if (tick) begin
        if (buf_full_q) begin
          active_d      = buf_q;
          buf_full_d    = 1'b0;
          sample_tick_d = 1'b1;
          state_d       = RUN;
        end else if (state_eff == RUN) begin
          underrun_d = 1'b1;
          if (underrun_cnt_q != URUN_MAX) begin
            underrun_cnt_d = underrun_cnt_q + 8'd1;
          end
        end
      end
    end

    // Only possible when the buffer is empty, so it never collides with a
    // tick draining a full buffer; a same-cycle empty tick still underruns.
    if (xfer) begin
      buf_d      = din;
      buf_full_d = 1'b1;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      buf_q          <= '0;
      buf_full_q     <= 1'b0;
      active_q       <= '0;
      sample_tick_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      buf_q          <= buf_d;
      buf_full_q     <= buf_full_d;
      active_q       <= active_d;
      sample_tick_q  <= sample_tick_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  // The modulator is fed the next active value so the bit after a tick
  // already reflects the new sample.
  dsm1 #(.WIDTH(WIDTH)) u_dsm1 (
    .clk     (clk),
    .rst     (rst),
    .run     (enable),
    .active  (active_d),
    .pdm_out (pdm_out)
  );

  assign din_ready    = !buf_full_q;
  assign sample_tick  = sample_tick_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: doc/pdm_dac.md
# pdm_dac

Output stage that takes the 16-bit unsigned samples produced by `filter` (`dout`) and turns them into a 1-bit pulse-density stream for an off-chip RC reconstruction filter. It uses a valid/ready handshake and a one-entry holding buffer. A programmable divider sets the sample rate, and a first-order error-feedback delta-sigma modulator runs every clock. Underruns are detected and counted.

## Interface
Parameters:
- `WIDTH`, 16: sample width; matches `filter` din/dout.
- `DIV_W`, 8: width of the sample-period divider.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `enable`  in  1  run modulator and sample timer.
- `div`  in  DIV_W  sample period minus 1, in clk cycles.
- `din`  in  WIDTH  unsigned sample (0 = silence floor, FFFF = full scale).
- `din_valid`  in  1  producer has a sample.
- `din_ready`  out  1  holding buffer empty (combinational, `!buf_full`).
- `pdm_out`  out  1  registered pulse-density output.
- `sample_tick`  out  1  one-cycle registered pulse when a new sample becomes active.
- `underrun`  out  1  sticky flag; cleared by reset or by `enable` falling.
- `underrun_cnt`  out  8  saturating underrun count.

## Operation
- Handshake: a transfer occurs when `din_valid && din_ready`, which sets `buf <= din` and `buf_full <= 1`. The producer must hold `din` stable while valid and not ready.
- Divider: `cnt` counts down from `div` to 0. At 0 a tick fires and `cnt` reloads from `div`. A change to `div` takes effect at the next reload.
- States:
  - IDLE (`enable` = 0): `pdm_out` = 0, `acc` = 0, `cnt` = `div`. The buffer still accepts one sample.
  - PRIME: enabled, waiting for the first sample. Go to RUN on the first tick with `buf_full`. Ticks with an empty buffer do not count as underruns.
  - RUN: on each tick with `buf_full`: `active <= buf`, `buf_full <= 0`, assert `sample_tick`. On a tick with an empty buffer: `active` is held (last sample repeats), `underrun <= 1`, `underrun_cnt` increments and saturates at FF.
  - Any state goes to IDLE when `enable` = 0. `active` and the buffer are kept; `underrun` and `underrun_cnt` are cleared.
- Modulator (PRIME and RUN, every clk): `{carry, acc} <= acc + active` (WIDTH+1 bit sum), `pdm_out <= carry`.
  - Ones density is active/2^16, so FFFF yields 65535 ones per 65536 cycles.
  - 0 yields a constant 0.
  - `acc` wraps modulo 2^16 and never saturates.
- Tick and transfer in the same cycle:
  - Buffer full: `din_ready` = 0 that cycle, so the transfer happens on a later cycle.
  - Buffer empty: an underrun is counted (RUN) and the sample is loaded into `buf`. There is no bypass to `active`.

## Timing
- Reset values: `pdm_out` 0, `sample_tick` 0, `underrun` 0, `underrun_cnt` 0, `din_ready` 1 (buffer empty), `acc` 0, `active` 0, state IDLE.
- Cycle T is the tick that loads `active`. `sample_tick` is high in T+1, and the first modulator bit using the new sample appears on `pdm_out` in T+1.
- The sample period is exactly `div`+1 clk cycles. `div` = 0 ticks every cycle, in which case the buffer drains each cycle and an underrun occurs whenever the producer stalls.
- Enable rising at cycle E: the first tick is at E+`div`.
- `rst` asserted mid-operation: all state returns to reset values on the next edge, and a pending buffered sample is discarded.

## Structure
- Shared package `audio_pkg`: `SAMPLE_W` = 16, the sample typedef, and the state enum (IDLE, PRIME, RUN). `filter` and `pdm_dac` share `SAMPLE_W`.
- Natural sub-module: `dsm1`, the first-order modulator (`clk`, `rst`, `run`, `active` → `pdm_out`). The divider, buffer and FSM stay in `pdm_dac`.

## Test plan
- Reset and idle: hold `rst` 2 cycles, `enable` = 0 → `pdm_out` 0, `din_ready` 1, `underrun_cnt` 00.
- DC density: `div` = 15, constant `din` = 4000 always valid, run 65536 cycles after the first `sample_tick` → exactly 16384 ones on `pdm_out`. `din` = 0000 → zero ones. `din` = FFFF → 65535 ones.
- Step at the boundary:
  - Expected: the first `pdm_out` bit reflecting the new value appears one cycle after the tick, and `sample_tick` pulses once per 16 cycles.
  - Stimulus: `din` 0000 then FFFF, presented one cycle before a tick.
- Underrun:
  - Stimulus: `div` = 3; feed one sample, then withhold valid for 5 ticks.
  - Expected: `underrun` = 1, `underrun_cnt` = 05, `active` unchanged.
  - Stimulus: continue withholding for 300 ticks. Expected: `underrun_cnt` saturates at FF.
  - Stimulus: drop `enable`. Expected: the count clears.
- Simultaneous tick and transfer with an empty buffer in RUN: `underrun_cnt` +1, `buf_full` 1, and the sample becomes `active` on the following tick.
- Mid-run reset: assert `rst` while `buf_full` = 1 and `acc` ≠ 0 → next cycle all outputs at reset values, `din_ready` 1, state IDLE.
